// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// mux selects, ALU function and write strobes out.
interface multicycle_ctrl_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero_flag;
   logic       sign_flag;
   logic [2:0] alu_control;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic       adr_src;
   logic       pc_write;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic       fault;
   logic [3:0] state_dbg;

   modport master (
      input  opcode, funct3, funct7b5, zero_flag, sign_flag,
      output alu_control, alu_src_a, alu_src_b, result_src, adr_src,
             pc_write, ir_write, mem_write, reg_write, fault, state_dbg
   );

   modport slave (
      output opcode, funct3, funct7b5, zero_flag, sign_flag,
      input  alu_control, alu_src_a, alu_src_b, result_src, adr_src,
             pc_write, ir_write, mem_write, reg_write, fault, state_dbg
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM.
//
//  state    | meaning
//  FETCH    | read instr at PC, IR <= mem, PC <= PC+4
//  DECODE   | ALUOut <= OldPC+imm, pick instruction class
//  MEMADR   | ALUOut <= rs1+imm (load/store address)
//  MEMREAD  | read data memory at ALUOut
//  MEMWB    | rd <= memory data
//  MEMWRITE | write rs2 to data memory at ALUOut
//  EXECR    | ALUOut <= rs1 op rs2
//  EXECI    | ALUOut <= rs1 op imm
//  ALUWB    | rd <= ALUOut
//  BRANCH   | compare rs1-rs2, PC <= ALUOut when taken
//  JAL      | PC <= ALUOut, ALUOut <= OldPC+4
//  FAULT    | unsupported instruction, halted until reset
module multicycle_ctrl #(
   parameter bit FAULT_HALT = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_FAULT    = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Unsupported instructions either halt or retire silently as a NOP.
   localparam state_t S_BAD = FAULT_HALT ? S_FAULT : S_FETCH;

   state_t     state, state_nxt;
   logic       func_ok, branch_ok, taken;
   logic [2:0] alu_func, alu_ctl;
   logic [1:0] src_a, src_b, res_src;
   logic       adr, pc_w, ir_w, mem_w, reg_w, flt;

   // State register; reset always lands on FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nxt;
   end

   assign func_ok   = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
   assign branch_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b100);

   // Next-state logic; illegal funct3 is rejected in DECODE, never executed.
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:    state_nxt = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_REG:            state_nxt = func_ok ? S_EXECR : S_BAD;
               OP_IMM:            state_nxt = func_ok ? S_EXECI : S_BAD;
               OP_BRANCH:         state_nxt = branch_ok ? S_BRANCH : S_BAD;
               OP_JAL:            state_nxt = S_JAL;
               default:           state_nxt = S_BAD;
            endcase
         end
         S_MEMADR:   state_nxt = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_nxt = S_MEMWB;
         S_MEMWB:    state_nxt = S_FETCH;
         S_MEMWRITE: state_nxt = S_FETCH;
         S_EXECR:    state_nxt = S_ALUWB;
         S_EXECI:    state_nxt = S_ALUWB;
         S_ALUWB:    state_nxt = S_FETCH;
         S_BRANCH:   state_nxt = S_FETCH;
         S_JAL:      state_nxt = S_ALUWB;
         S_FAULT:    state_nxt = S_FAULT;
         default:    state_nxt = S_FETCH;
      endcase
   end

   // ALU function for EXECR/EXECI and branch resolution from the ALU flags.
   always_comb begin
      alu_func = ALU_ADD;
      taken    = 1'b0;
      case (bus.funct3)
         3'b000:  alu_func = (state == S_EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_func = ALU_SLT;
         3'b110:  alu_func = ALU_OR;
         3'b111:  alu_func = ALU_AND;
         default: alu_func = ALU_ADD;
      endcase
      case (bus.funct3)
         3'b000:  taken = bus.zero_flag;
         3'b001:  taken = !bus.zero_flag;
         3'b100:  taken = bus.sign_flag;
         default: taken = 1'b0;
      endcase
   end

   // Moore output decode of the state register.
   always_comb begin
      alu_ctl = ALU_ADD;
      src_a   = 2'b00;
      src_b   = 2'b00;
      res_src = 2'b00;
      adr     = 1'b0;
      pc_w    = 1'b0;
      ir_w    = 1'b0;
      mem_w   = 1'b0;
      reg_w   = 1'b0;
      flt     = 1'b0;
      case (state)
         S_FETCH: begin
            ir_w    = 1'b1;
            src_b   = 2'b10;
            res_src = 2'b10;
            pc_w    = 1'b1;
         end
         S_DECODE: begin
            src_a = 2'b01;
            src_b = 2'b01;
         end
         S_MEMADR: begin
            src_a = 2'b10;
            src_b = 2'b01;
         end
         S_MEMREAD:  adr = 1'b1;
         S_MEMWB: begin
            res_src = 2'b01;
            reg_w   = 1'b1;
         end
         S_MEMWRITE: begin
            adr   = 1'b1;
            mem_w = 1'b1;
         end
         S_EXECR: begin
            src_a   = 2'b10;
            alu_ctl = alu_func;
         end
         S_EXECI: begin
            src_a   = 2'b10;
            src_b   = 2'b01;
            alu_ctl = alu_func;
         end
         S_ALUWB:    reg_w = 1'b1;
         S_BRANCH: begin
            src_a   = 2'b10;
            alu_ctl = ALU_SUB;
            pc_w    = taken;
         end
         S_JAL: begin
            src_a = 2'b01;
            src_b = 2'b10;
            pc_w  = 1'b1;
         end
         S_FAULT:    flt = 1'b1;
         default: ;
      endcase
   end

   // Strobes are masked during reset so the FETCH decode cannot write anything.
   assign bus.alu_control = alu_ctl;
   assign bus.alu_src_a   = src_a;
   assign bus.alu_src_b   = src_b;
   assign bus.result_src  = res_src;
   assign bus.adr_src     = adr;
   assign bus.pc_write    = pc_w  & rst_n;
   assign bus.ir_write    = ir_w  & rst_n;
   assign bus.mem_write   = mem_w & rst_n;
   assign bus.reg_write   = reg_w & rst_n;
   assign bus.fault       = flt   & rst_n;
   assign bus.state_dbg   = state;
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM for the multi-cycle RV32I-subset datapath. It is the initiator side of the ALU interface.
- Sequences fetch/decode/execute/memory/writeback over several cycles.
- Issues alu_control codes to the ALU and consumes its zero_flag/sign_flag to resolve branches.
- Drives all datapath mux selects and write strobes; sits between the instruction register and the shared datapath.

Parameters:
FAULT_HALT, 1, 1: unsupported opcode/funct3 enters FAULT and halts until reset; 0: treated as NOP (DECODE -> FETCH, no writes).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero_flag  input  1  ALU result == 0
sign_flag  input  1  ALU result MSB
alu_control  output  3  000 add, 001 sub, 010 or, 011 and, 101 slt
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 data
alu_src_b  output  2  00 rs2 data, 01 immediate, 10 constant 4
result_src  output  2  00 ALUOut reg, 01 memory data reg, 10 live ALU result
adr_src  output  1  memory address: 0 PC, 1 result
pc_write  output  1  PC load strobe
ir_write  output  1  instruction register load strobe
mem_write  output  1  data memory write strobe
reg_write  output  1  register file write strobe
fault  output  1  FAULT state indicator
state_dbg  output  4  current state encoding

Behaviour:
- Outputs are Moore decodes of the state register. pc_write in BRANCH additionally depends on the flags.
- Reset:
  - rst_n low forces state = FETCH asynchronously.
  - While rst_n is low, pc_write/ir_write/mem_write/reg_write/fault = 0; other outputs show FETCH values.
  - Reset mid-instruction abandons it with no further strobes.
- Default outputs in every state: strobes 0, selects 00, alu_control add, unless listed below.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, FAULT 15.
- States and transitions:
  - FETCH: adr_src 0, ir_write 1, a=00, b=10, add, result_src 10, pc_write 1 -> DECODE.
  - DECODE: a=01, b=01, add (branch/jump target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - other -> FAULT (FAULT_HALT=1) or FETCH.
  - MEMADR: a=10, b=01, add. Next: opcode bit5 = 0 -> MEMREAD, 1 -> MEMWRITE.
  - MEMREAD: adr_src 1, result_src 00 -> MEMWB.
  - MEMWB: result_src 01, reg_write 1 -> FETCH.
  - MEMWRITE: adr_src 1, result_src 00, mem_write 1 -> FETCH.
  - EXECR: a=10, b=00, function decode -> ALUWB.
  - EXECI: a=10, b=01, function decode -> ALUWB.
  - ALUWB: result_src 00, reg_write 1 -> FETCH.
  - BRANCH: a=10, b=00, sub, result_src 00, pc_write = taken -> FETCH.
    - funct3 000 (beq): taken = zero_flag.
    - funct3 001 (bne): taken = !zero_flag.
    - funct3 100 (blt): taken = sign_flag.
  - JAL: a=01, b=10, add, result_src 00, pc_write 1 -> ALUWB (rd = PC+4).
  - FAULT: all strobes 0, fault 1. Self-loop; only rst_n exits.
- Function decode (EXECR/EXECI):
  - funct3 000: sub if EXECR and funct7b5 = 1, else add (addi ignores funct7b5).
  - funct3 010: slt. funct3 110: or. funct3 111: and.
- Illegal funct3:
  - OP/OP-IMM funct3 outside {000, 010, 110, 111}, or branch funct3 outside {000, 001, 100}, is caught in DECODE.
  - Next state = FAULT (FAULT_HALT=1) or FETCH; the instruction is never executed.
- Latency in cycles: lw 5, sw 4, R/I-type 4, branch 3, jal 4.
- Flags are sampled only in BRANCH and ignored elsewhere.

Test Plan:
1. rst_n low mid-MEMWRITE, release -> mem_write drops to 0 immediately on assert; state_dbg=0; ir_write=1 on first post-reset cycle.
2. lw (opcode 0000011) -> state_dbg 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; adr_src=1 in state 3.
3. R-type sub (funct3 000, funct7b5 1) -> EXECR alu_control=001, a=10, b=00; ALUWB reg_write=1; 4 cycles. Same with opcode 0010011 -> alu_control=000.
4. beq with zero_flag=1 -> BRANCH pc_write=1, alu_control=001. With zero_flag=0 -> pc_write=0. blt with sign_flag=1 -> pc_write=1.
5. jal -> JAL pc_write=1, a=01, b=10; then ALUWB reg_write=1; back to FETCH after 4 cycles.
6. opcode 1111111, FAULT_HALT=1 -> state 15, fault=1, no strobes for 20 cycles until rst_n. With FAULT_HALT=0 -> DECODE -> FETCH, no writes.
